// File: rtl/ascon_rate_packer_if.sv
// Word-in / block-out handshake bundle for the ASCON rate packer.
// master drives words and out_ready; slave is the packer.
interface ascon_rate_packer_if #(
  parameter int DATA_W = 32,
  parameter int RATE_W = 64
);
  localparam int NB = $clog2(DATA_W/8) + 1;
  localparam int RB = $clog2(RATE_W/8) + 1;

  logic [DATA_W-1:0] in_data;
  logic [NB-1:0]     in_bytes;
  logic [1:0]        in_type;
  logic              in_valid;
  logic              in_last;
  logic              in_ready;
  logic [RATE_W-1:0] out_block;
  logic [RB-1:0]     out_bytes;
  logic [1:0]        out_type;
  logic              out_valid;
  logic              out_last;
  logic              out_ready;

  modport master (
    output in_data, in_bytes, in_type, in_valid, in_last, out_ready,
    input  in_ready, out_block, out_bytes, out_type, out_valid, out_last
  );
  modport slave (
    input  in_data, in_bytes, in_type, in_valid, in_last, out_ready,
    output in_ready, out_block, out_bytes, out_type, out_valid, out_last
  );
endinterface

// File: rtl/ascon_rate_packer.sv
// Packs DATA_W-bit words big-endian into RATE_W-bit ASCON rate blocks and
// appends 0x80 padding, with a separate pad-only block on exact boundaries.
module ascon_rate_packer #(
  parameter int DATA_W = 32,
  parameter int RATE_W = 64
) (
  input  logic               i_clk,
  input  logic               i_rst,
  ascon_rate_packer_if.slave bus
);
  localparam int WB  = DATA_W/8;
  localparam int RBY = RATE_W/8;
  localparam int RB  = $clog2(RBY) + 1;

  typedef enum logic [1:0] {S_FILL, S_EMIT, S_PAD} state_t;

  state_t            r_state;
  logic [RB-1:0]     r_fill;
  logic [RATE_W-1:0] r_acc;
  logic              r_pad;
  logic              r_inmsg;
  logic              r_in_ready;
  logic              r_valid;
  logic              r_last;
  logic [RB-1:0]     r_bytes;
  logic [RATE_W-1:0] r_block;
  logic [1:0]        r_type;

  int                w_k;
  int                w_end;
  logic [RATE_W-1:0] w_acc;

  // Merge the incoming word at byte offset r_fill; a last word also drops the
  // 0x80 marker right behind its final byte (bytes past it are already zero).
  always_comb begin
    w_k = WB;
    if (bus.in_last && int'(bus.in_bytes) < WB) w_k = int'(bus.in_bytes);
    w_end = int'(r_fill) + w_k;
    w_acc = r_acc;
    for (int j = 0; j < RBY; j++) begin
      if (j >= int'(r_fill) && j < w_end)
        w_acc[RATE_W-1-8*j -: 8] = bus.in_data[DATA_W-1-8*(j-int'(r_fill)) -: 8];
      else if (bus.in_last && j == w_end)
        w_acc[RATE_W-1-8*j -: 8] = 8'h80;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= S_FILL;
      r_fill     <= '0;
      r_acc      <= '0;
      r_pad      <= 1'b0;
      r_inmsg    <= 1'b0;
      r_in_ready <= 1'b1;
      r_valid    <= 1'b0;
      r_last     <= 1'b0;
      r_bytes    <= '0;
      r_block    <= '0;
      r_type     <= '0;
    end else begin
      case (r_state)
        S_FILL: if (bus.in_valid) begin
          r_inmsg <= 1'b1;
          if (!r_inmsg && r_fill == '0) r_type <= bus.in_type;
          if (bus.in_last || w_end == RBY) begin
            r_block    <= w_acc;
            r_bytes    <= w_end[RB-1:0];
            r_last     <= bus.in_last && (w_end < RBY);
            r_pad      <= bus.in_last && (w_end == RBY);
            r_valid    <= 1'b1;
            r_in_ready <= 1'b0;
            r_fill     <= '0;
            r_acc      <= '0;
            r_state    <= S_EMIT;
          end else begin
            r_fill <= w_end[RB-1:0];
            r_acc  <= w_acc;
          end
        end
        S_EMIT: if (bus.out_ready) begin
          if (r_pad) begin
            r_block <= {8'h80, {(RATE_W-8){1'b0}}};
            r_bytes <= '0;
            r_last  <= 1'b1;
            r_state <= S_PAD;
          end else begin
            r_valid    <= 1'b0;
            r_in_ready <= 1'b1;
            if (r_last) r_inmsg <= 1'b0;
            r_state    <= S_FILL;
          end
        end
        S_PAD: if (bus.out_ready) begin
          r_pad      <= 1'b0;
          r_valid    <= 1'b0;
          r_in_ready <= 1'b1;
          r_inmsg    <= 1'b0;
          r_state    <= S_FILL;
        end
        default: r_state <= S_FILL;
      endcase
    end
  end

  assign bus.in_ready  = r_in_ready;
  assign bus.out_valid = r_valid;
  assign bus.out_last  = r_last;
  assign bus.out_bytes = r_bytes;
  assign bus.out_block = r_block;
  assign bus.out_type  = r_type;
endmodule

// File: tb/tb_ascon_rate_packer.sv
// Randomised + directed bench for two packer configs (32/64 and 32/128)
// against a byte-queue model of ASCON chunking and padding.
module tb_ascon_rate_packer;
  localparam logic [1:0] TYPE_AD    = 2'd0;
  localparam logic [1:0] TYPE_PLAIN = 2'd1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic sel = 1'b0;
  logic [31:0] in_data = '0;
  logic [2:0]  in_bytes = '0;
  logic [1:0]  in_type = '0;
  logic        in_valid = 1'b0;
  logic        in_last = 1'b0;
  logic        out_ready = 1'b1;

  always #5 clk = ~clk;

  ascon_rate_packer_if #(.DATA_W(32), .RATE_W(64))  ba();
  ascon_rate_packer_if #(.DATA_W(32), .RATE_W(128)) bb();

  assign ba.in_data = in_data;  assign bb.in_data = in_data;
  assign ba.in_bytes = in_bytes; assign bb.in_bytes = in_bytes;
  assign ba.in_type = in_type;  assign bb.in_type = in_type;
  assign ba.in_last = in_last;  assign bb.in_last = in_last;
  assign ba.in_valid = in_valid & ~sel;
  assign bb.in_valid = in_valid & sel;
  assign ba.out_ready = out_ready; assign bb.out_ready = out_ready;

  ascon_rate_packer #(.DATA_W(32), .RATE_W(64))  dut_a (.i_clk(clk), .i_rst(rst), .bus(ba));
  ascon_rate_packer #(.DATA_W(32), .RATE_W(128)) dut_b (.i_clk(clk), .i_rst(rst), .bus(bb));

  wire         a_vld   = sel ? bb.out_valid : ba.out_valid;
  wire         o_vld   = sel ? ba.out_valid : bb.out_valid;
  wire         a_irdy  = sel ? bb.in_ready  : ba.in_ready;
  wire [127:0] a_blk   = sel ? bb.out_block : {64'h0, ba.out_block};
  wire [4:0]   a_bytes = sel ? bb.out_bytes : {1'b0, ba.out_bytes};
  wire         a_last  = sel ? bb.out_last  : ba.out_last;
  wire [1:0]   a_type  = sel ? bb.out_type  : ba.out_type;

  typedef struct { logic [127:0] blk; int bytes; bit last; logic [1:0] typ; } blk_t;
  blk_t exp_q[$];
  blk_t got_q[$];
  logic [7:0] part[$];
  bit         m_inmsg = 0;
  logic [1:0] m_type = '0;

  int vec = 0, errs = 0;
  bit rand_rdy = 0, hold_mode = 0, held = 0, cons_flag = 0;
  int hold_cnt = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    vec++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic int rby();
    return sel ? 16 : 8;
  endfunction

  // Message bytes are chunked into rate blocks; the message always ends with
  // one padded block holding the remaining (possibly zero) bytes.
  task automatic model_accept(input logic [31:0] d, input int b, input bit l, input logic [1:0] t);
    int k; blk_t e;
    if (!m_inmsg) begin m_type = t; m_inmsg = 1; end
    k = l ? (b < 4 ? b : 4) : 4;
    for (int i = 0; i < k; i++) part.push_back(d[31-8*i -: 8]);
    if (part.size() == rby()) begin
      e.blk = '0;
      foreach (part[i]) e.blk = {e.blk[119:0], part[i]};
      e.bytes = rby(); e.last = 0; e.typ = m_type;
      exp_q.push_back(e);
      part.delete();
    end
    if (l) begin
      e.blk = '0;
      for (int i = 0; i < rby(); i++)
        e.blk = {e.blk[119:0], (i < part.size()) ? part[i] : ((i == part.size()) ? 8'h80 : 8'h00)};
      e.bytes = part.size(); e.last = 1; e.typ = m_type;
      exp_q.push_back(e);
      part.delete();
      m_inmsg = 0;
    end
  endtask

  always @(negedge clk) begin
    blk_t e, g;
    cons_flag = 0;
    if (!rst) begin
      chk("idle_cfg_valid", {127'h0, o_vld}, 128'h0);
      if (a_vld) begin
        chk("in_ready_during_emit", {127'h0, a_irdy}, 128'h0);
        if (exp_q.size() == 0) begin
          vec++; errs++;
          $display("FAIL extra_block: got %0h expected no block", a_blk);
        end else begin
          e = exp_q[0];
          chk("out_block", a_blk, e.blk);
          chk("out_bytes", {123'h0, a_bytes}, e.bytes);
          chk("out_last", {127'h0, a_last}, {127'h0, e.last});
          chk("out_type", {126'h0, a_type}, {126'h0, e.typ});
          if (out_ready) begin
            void'(exp_q.pop_front());
            g.blk = a_blk; g.bytes = a_bytes; g.last = a_last; g.typ = a_type;
            got_q.push_back(g);
          end
        end
        cons_flag = out_ready;
      end
    end
  end

  always @(posedge clk) begin
    #1;
    if (cons_flag) held = 0;
    if (hold_mode && a_vld && !held) begin held = 1; hold_cnt = 5; end
    if (hold_cnt > 0) begin out_ready = 1'b0; hold_cnt--; end
    else out_ready = rand_rdy ? ($urandom_range(0, 3) != 0) : 1'b1;
  end

  task automatic send(input logic [31:0] d, input int b, input bit l, input logic [1:0] t);
    in_data = d; in_bytes = b[2:0]; in_last = l; in_type = t; in_valid = 1'b1;
    for (int n = 0; n < 500; n++) begin
      @(negedge clk);
      if (a_irdy) begin
        model_accept(d, b, l, t);
        @(posedge clk); #1;
        in_valid = 1'b0;
        return;
      end
      @(posedge clk); #1;
    end
    vec++; errs++;
    $display("FAIL accept_timeout: got in_ready=0 expected word accepted");
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_q.size() != 0 || a_vld) && n < 2000) begin @(posedge clk); #1; n++; end
    if (n >= 2000) begin
      vec++; errs++;
      $display("FAIL drain_timeout: got %0d blocks pending expected 0", exp_q.size());
    end
  endtask

  task automatic lit(input int idx, input logic [127:0] blk, input int bytes, input bit last, input logic [1:0] t);
    if (got_q.size() <= idx) begin
      vec++; errs++;
      $display("FAIL lit_missing: got %0d blocks expected index %0d", got_q.size(), idx);
    end else begin
      chk("lit_block", got_q[idx].blk, blk);
      chk("lit_bytes", got_q[idx].bytes, bytes);
      chk("lit_last", {127'h0, got_q[idx].last}, {127'h0, last});
      chk("lit_type", {126'h0, got_q[idx].typ}, {126'h0, t});
    end
  endtask

  task automatic rand_msgs(input int cnt);
    int nw;
    rand_rdy = 1;
    for (int m = 0; m < cnt; m++) begin
      nw = $urandom_range(1, 8);
      for (int w = 0; w < nw; w++) begin
        if ($urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
        send($urandom, $urandom_range(0, 7), w == nw-1, 2'($urandom_range(0, 3)));
      end
    end
    drain();
    rand_rdy = 0;
  endtask

  task automatic check_reset_state();
    @(negedge clk);
    chk("rst_a_valid", {127'h0, ba.out_valid}, 128'h0);
    chk("rst_a_ready", {127'h0, ba.in_ready}, 128'h1);
    chk("rst_a_block", {64'h0, ba.out_block}, 128'h0);
    chk("rst_a_bytes", {124'h0, ba.out_bytes}, 128'h0);
    chk("rst_a_last",  {127'h0, ba.out_last}, 128'h0);
    chk("rst_a_type",  {126'h0, ba.out_type}, 128'h0);
    chk("rst_b_valid", {127'h0, bb.out_valid}, 128'h0);
    chk("rst_b_ready", {127'h0, bb.in_ready}, 128'h1);
    chk("rst_b_block", bb.out_block, 128'h0);
    @(posedge clk); #1;
  endtask

  initial begin
    int b;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check_reset_state();

    b = got_q.size();
    send(32'h6e000000, 1, 1, TYPE_PLAIN);
    drain();
    lit(b, 128'h6e80000000000000, 1, 1, TYPE_PLAIN);

    b = got_q.size();
    send(32'h01020304, 0, 0, TYPE_PLAIN);
    send(32'h05060708, 4, 1, TYPE_AD);
    drain();
    lit(b,   128'h0102030405060708, 8, 0, TYPE_PLAIN);
    lit(b+1, 128'h8000000000000000, 0, 1, TYPE_PLAIN);

    b = got_q.size();
    send(32'h0, 0, 1, 2'd2);
    drain();
    lit(b, 128'h8000000000000000, 0, 1, 2'd2);
    chk("empty_single_block", got_q.size() - b, 1);

    b = got_q.size();
    hold_mode = 1;
    send(32'hAABBCCDD, 0, 0, 2'd3);
    send(32'h11223344, 0, 0, TYPE_PLAIN);
    send(32'h55000000, 1, 1, TYPE_AD);
    drain();
    hold_mode = 0;
    lit(b,   128'hAABBCCDD11223344, 8, 0, 2'd3);
    lit(b+1, 128'h5580000000000000, 1, 1, 2'd3);

    send(32'hFFFFFFFF, 0, 0, 2'd3);
    rst = 1'b1; part.delete(); exp_q.delete(); m_inmsg = 0;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("midrst_valid", {127'h0, ba.out_valid}, 128'h0);
    chk("midrst_ready", {127'h0, ba.in_ready}, 128'h1);
    @(posedge clk); #1;
    b = got_q.size();
    send(32'h6e000000, 1, 1, TYPE_PLAIN);
    drain();
    lit(b, 128'h6e80000000000000, 1, 1, TYPE_PLAIN);

    rand_msgs(40);

    sel = 1'b1;
    @(posedge clk); #1;
    b = got_q.size();
    send(32'h01020304, 0, 0, TYPE_PLAIN);
    send(32'h05060708, 0, 0, TYPE_PLAIN);
    send(32'h090A0B0C, 0, 0, TYPE_PLAIN);
    send(32'hDEADBE00, 3, 1, TYPE_PLAIN);
    drain();
    lit(b, 128'h0102030405060708090A0B0CDEADBE80, 15, 1, TYPE_PLAIN);

    b = got_q.size();
    send(32'h01020304, 0, 0, TYPE_AD);
    send(32'h05060708, 0, 0, TYPE_AD);
    send(32'h090A0B0C, 0, 0, TYPE_AD);
    send(32'hDEADBEEF, 7, 1, TYPE_AD);
    drain();
    lit(b,   128'h0102030405060708090A0B0CDEADBEEF, 16, 0, TYPE_AD);
    lit(b+1, 128'h80000000000000000000000000000000, 0, 1, TYPE_AD);

    rand_msgs(40);

    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

  initial begin
    #800000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/ascon_rate_packer.md
Name: ascon_rate_packer

Overview:
Parametrised input stage for the ASCON core's associated-data and plaintext/ciphertext paths. It accepts a stream of DATA_W-bit words, packs them big-endian into RATE_W-bit rate blocks and applies ASCON padding: a 0x80 byte after the last message byte, zeros after that. It emits an extra pad-only block when the message ends exactly on a block boundary, and handles empty messages. It generalises the fixed 32-bit ingress to selectable word width and rate (64 for Ascon-128, 128 for Ascon-128a).

Parameters:
DATA_W, 32, input word width in bits; one of 8/16/32/64.
RATE_W, 64, rate block width in bits; 64 or 128; must be a multiple of DATA_W and >= DATA_W.
(derived) NB = log2(DATA_W/8)+1 and RB = log2(RATE_W/8)+1, byte-count widths.

Ports:
clk  in  1  clock; all logic on rising edge.
rst  in  1  synchronous, active-high reset.
in_data  in  DATA_W  input word; the first byte is in the MSBs.
in_bytes  in  NB  valid byte count (0..DATA_W/8); only used when in_last=1.
in_type  in  2  data type (TYPE_* encoding); sampled on the first word of a message.
in_valid  in  1  input word valid.
in_last  in  1  final word of the message.
in_ready  out  1  packer accepts a word this cycle.
out_block  out  RATE_W  packed, padded rate block; first byte in the MSBs.
out_bytes  out  RB  real message bytes in out_block (0..RATE_W/8).
out_type  out  2  type latched for the current message.
out_valid  out  1  out_block valid.
out_last  out  1  final block of the message; always carries the padding.
out_ready  in  1  downstream accepts the block.

Behaviour:
- Reset (rst=1 at a clock edge): state FILL; fill=0; accumulator=0; out_valid=0; out_last=0; out_bytes=0; out_block=0; out_type=0. Reset overrides any in-flight block, including one held under backpressure, and drops it.
- Transfer rules:
  - A word is accepted when in_valid && in_ready.
  - A block is consumed when out_valid && out_ready.
  - out_block, out_bytes, out_type and out_last hold stable while out_valid=1 && out_ready=0.
- Byte placement: accepted word bytes go to accumulator byte positions fill .. fill+k-1, with position 0 at the MSB.
  - k = DATA_W/8 when in_last=0.
  - k = min(in_bytes, DATA_W/8) when in_last=1; over-range in_bytes is clamped.
- FILL state (in_ready=1, out_valid=0):
  - Non-last word, fill+k < RATE_W/8: fill += k; stay in FILL.
  - Non-last word, fill+k = RATE_W/8: go to EMIT with out_last=0 and out_bytes=RATE_W/8.
  - Last word, fill+k < RATE_W/8: write 0x80 at byte position fill+k and zero the remaining bytes. Go to EMIT with out_last=1 and out_bytes=fill+k.
  - Last word, fill+k = RATE_W/8: go to EMIT with out_last=0 and out_bytes=RATE_W/8, and set pad_pending=1.
  - in_type is latched when fill=0 and no message is in progress. Type changes later in the same message are ignored.
- EMIT state (in_ready=0, out_valid=1). On consume:
  - If pad_pending: go to EMIT_PAD.
  - Otherwise: clear fill and the accumulator, then return to FILL.
  - The message-in-progress flag clears after a block with out_last=1.
- EMIT_PAD state (in_ready=0, out_valid=1):
  - out_block = 0x80 followed by zeros; out_bytes=0; out_last=1.
  - On consume: clear pad_pending and return to FILL.
- Empty message: in_last=1 with in_bytes=0 at fill=0 produces a single pad-only block (out_bytes=0, out_last=1).
- Latency: out_valid rises the cycle after the word that completes a block is accepted. The input stalls while a block is pending; there is no overlap.
- Throughput:
  - DATA_W=32, RATE_W=64: 2 input cycles plus 1 emit cycle per block at out_ready=1.
  - DATA_W=RATE_W: 1 input cycle plus 1 emit cycle per block.
- in_bytes is ignored when in_last=0; all non-last words are treated as full.

Test Plan:
1. DATA_W=32, RATE_W=64. Send 0x6e000000 with in_last=1, in_bytes=1 -> one block 0x6e80000000000000, out_bytes=1, out_last=1, out_type=TYPE_PLAIN.
2. Send 0x01020304, then 0x05060708 with last=1, bytes=4 -> first block 0x0102030405060708 (bytes=8, last=0), then 0x8000000000000000 (bytes=0, last=1). in_ready stays 0 across both emit cycles.
3. Empty message: in_last=1, in_bytes=0 at idle -> exactly one block 0x8000000000000000, bytes=0, last=1.
4. Send 0xAABBCCDD, 0x11223344, then 0x55000000 with last=1, bytes=1 -> first block 0xAABBCCDD11223344 (last=0), then 0x5580000000000000 (bytes=1, last=1). Hold out_ready=0 for 5 cycles on each block -> outputs stable, in_ready=0, nothing lost or duplicated.
5. DATA_W=32, RATE_W=128. Send 3 full words plus a last word with bytes=3 (0xDEADBE00) -> a single block ending ...DEADBE80 (bytes=15, last=1). Last word with bytes=7 -> clamped to 4, giving bytes=16, last=0, then a pad block.
6. Reset mid-message: accept 1 word, assert rst for 1 cycle -> out_valid=0, in_ready=1, fill=0. Then send 0x6e000000 with last=1, bytes=1 -> block 0x6e80000000000000 with no residue from the aborted message.
